// File: rtl/bram_result_writer_pkg.sv
// Shared types and default geometry for the BRAM result writer.
package bram_result_writer_pkg;

  // Default geometry: 64 lanes of 16 bits, 16 beats per capture run.
  localparam int DEF_N     = 64;
  localparam int DEF_W     = 16;
  localparam int DEF_DEPTH = 16;

  // Address width for a RAM of the given depth.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Widths at the default geometry.
  localparam int ADDR_W = addr_width(DEF_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int BEAT_W = DEF_N * DEF_W;

  // Capture controller states.
  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/bram_result_writer_result_ram.sv
// Simple dual-port result RAM: one write port and one registered,
// read-first read port. Sized DEPTH x BEAT_W and written for BRAM inference.
module bram_result_writer_result_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int BEAT_W = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BEAT_W-1:0] rd_data
);

  logic [BEAT_W-1:0] mem [DEPTH];

  // Write port: store the beat at the current write address.
  // NOTE: the array has no reset; clearing it would stop BRAM inference, and
  // stored results are only meaningful once a capture run has written them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; reading the entry being written returns old data.
  // NOTE: non-blocking assignment is what gives read-first behaviour here -
  // the read samples mem before the same-edge write takes effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bram_result_writer.sv
// Sink-side result writer: captures DEPTH valid beats into the result RAM in
// arrival order, then stops and flags completion until re-armed. A readback
// port drains the RAM independently of the capture state.
module bram_result_writer
  import bram_result_writer_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arm,
  input  logic                            valid_in,
  input  logic [N*W-1:0]                  data_in,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [addr_width(DEPTH):0]      count,
  input  logic                            rd_en,
  input  logic [addr_width(DEPTH)-1:0]    rd_addr,
  output logic [N*W-1:0]                  rd_data,
  output logic                            rd_valid
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = N * W;

  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic          wr_en;

  // Only beats arriving while capturing reach the RAM.
  assign wr_en = (state == ST_CAPTURE) && valid_in;

  // Capture controller: state, write pointer, beat count and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_CAPTURE;
      wr_addr  <= '0;
      count    <= '0;
      overflow <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (valid_in) begin
            // Power-of-two depth: the pointer wraps to 0 on the last beat.
            wr_addr <= wr_addr + AW'(1);
            count   <= count + CW'(1);
            if (count == LAST_CNT) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Re-arming wins over a same-cycle beat, which is simply dropped.
          if (arm) begin
            state    <= ST_CAPTURE;
            wr_addr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end else if (valid_in) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state <= ST_CAPTURE;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // rd_valid marks the cycle after each read request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  bram_result_writer_result_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .BEAT_W (BW)
  ) u_result_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
